// File: rtl/ray_dispatcher_if.sv
// Ray dispatcher bus bundle: rtunit request/response plus the pixel record stream.
//   master = ray_dispatcher, slave = rtunit + downstream pixel sink.
// Handshakes:
//   - rtunit request: valid is a one-cycle pulse carrying origin/dir/tmax. The rtunit
//     signals completion by raising done (held >= 1 cycle). Only the rising edge counts.
//   - pixel stream: pix_valid/pix_ready. A record transfers on a cycle where both are
//     high. While pix_valid is high and pix_ready is low, every pix_* field stays stable.
interface ray_dispatcher_if;
    // rtunit request
    logic        valid;
    logic [31:0] origin_x;
    logic [31:0] origin_y;
    logic [31:0] origin_z;
    logic [31:0] dir_x;
    logic [31:0] dir_y;
    logic [31:0] dir_z;
    logic [31:0] tmax;
    // rtunit response
    logic        done;
    logic        intersected;
    logic [31:0] t;
    logic [31:0] u;
    logic [31:0] v;
    logic [31:0] n_x;
    logic [31:0] n_y;
    logic [31:0] n_z;
    // pixel record stream
    logic        pix_valid;
    logic        pix_ready;
    logic [10:0] pix_row;
    logic [10:0] pix_col;
    logic        pix_hit;
    logic [31:0] pix_t;
    logic [31:0] pix_nx;
    logic [31:0] pix_ny;
    logic [31:0] pix_nz;

    modport master (
        output valid, origin_x, origin_y, origin_z, dir_x, dir_y, dir_z, tmax,
        input  done, intersected, t, u, v, n_x, n_y, n_z,
        output pix_valid, pix_row, pix_col, pix_hit, pix_t, pix_nx, pix_ny, pix_nz,
        input  pix_ready
    );

    modport slave (
        input  valid, origin_x, origin_y, origin_z, dir_x, dir_y, dir_z, tmax,
        output done, intersected, t, u, v, n_x, n_y, n_z,
        input  pix_valid, pix_row, pix_col, pix_hit, pix_t, pix_nx, pix_ny, pix_nz,
        output pix_ready
    );
endinterface

// File: rtl/ray_dispatcher.sv
// ray_dispatcher: scans a WIDTH x HEIGHT grid in raster order, issues one pinhole
// camera ray per pixel to the rtunit, waits for completion and forwards the hit
// result as a pixel record on a valid/ready stream.
// Optional: define RAY_DISPATCHER_TIMEOUT_EN to add a 16-bit WAIT watchdog and a
// one-cycle timeout output pulse.
// dbg_state exposes the FSM state: 0 IDLE, 1 ISSUE, 2 WAIT, 3 OUT, 4 GAP.
module ray_dispatcher #(
    parameter int          WIDTH      = 100,
    parameter int          HEIGHT     = 100,
    parameter int          FOCAL      = 100,
    parameter logic [31:0] ORIGIN_X   = 32'h00000000,
    parameter logic [31:0] ORIGIN_Y   = 32'h00000000,
    parameter logic [31:0] ORIGIN_Z   = 32'h3F800000,
    parameter logic [31:0] TMAX       = 32'h7F7FFFFF,
    parameter int          GAP_CYCLES = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    output logic             busy,
    output logic             frame_done,
    output logic [2:0]       dbg_state,
    ray_dispatcher_if.master rt
`ifdef RAY_DISPATCHER_TIMEOUT_EN
    ,
    output logic             timeout
`endif
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        WAIT  = 3'd2,
        OUT   = 3'd3,
        GAP   = 3'd4
    } state_t;

    state_t      state;
    logic [10:0] i;
    logic [10:0] j;
    logic [10:0] i_adv;
    logic [10:0] j_adv;
    logic        last_pix;
    logic [7:0]  gap_cnt;
    logic        done_q;
    logic        done_rise;
    logic        unused_uv;

`ifdef RAY_DISPATCHER_TIMEOUT_EN
    logic [15:0] wdog;
`endif

    // Exact int -> IEEE single for |v| < 2^24: no rounding is ever needed.
    function automatic logic [31:0] int_to_float(input logic signed [31:0] v);
        logic [31:0] mag;
        logic [22:0] mant;
        logic [4:0]  msb;
        logic [7:0]  expo;
        mag = v[31] ? 32'(-v) : 32'(v);
        msb = 5'd0;
        for (int k = 0; k < 24; k++) begin
            if (mag[k]) msb = 5'(k);
        end
        mant = 23'(mag << (5'd23 - msb));
        expo = 8'd127 + 8'(msb);
        if (mag == 32'd0) return 32'd0;
        return {v[31], expo, mant};
    endfunction

    // dx = 2j - (WIDTH-1)
    function automatic logic [31:0] dir_x_of(input logic [10:0] col);
        logic signed [31:0] d;
        d = $signed({20'd0, col, 1'b0}) - 32'(WIDTH - 1);
        return int_to_float(d);
    endfunction

    // dy = (HEIGHT-1) - 2i
    function automatic logic [31:0] dir_y_of(input logic [10:0] row);
        logic signed [31:0] d;
        d = 32'(HEIGHT - 1) - $signed({20'd0, row, 1'b0});
        return int_to_float(d);
    endfunction

    localparam logic [31:0] DIR_Z = int_to_float(32'(-FOCAL));

    assign rt.origin_x = ORIGIN_X;
    assign rt.origin_y = ORIGIN_Y;
    assign rt.origin_z = ORIGIN_Z;
    assign rt.tmax     = TMAX;
    assign dbg_state   = state;
    assign done_rise   = rt.done & ~done_q;
    assign unused_uv   = ^{rt.u, rt.v};

    // Raster advance: next column, wrapping to the start of the next row.
    always_comb begin
        last_pix = (i == 11'(HEIGHT - 1)) && (j == 11'(WIDTH - 1));
        i_adv    = i;
        j_adv    = j + 11'd1;
        if (j == 11'(WIDTH - 1)) begin
            j_adv = 11'd0;
            i_adv = i + 11'd1;
        end
    end

    // Dispatcher FSM; every output is registered and set on the edge entering its state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            i          <= 11'd0;
            j          <= 11'd0;
            gap_cnt    <= 8'd0;
            done_q     <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            rt.valid   <= 1'b0;
            rt.dir_x   <= 32'd0;
            rt.dir_y   <= 32'd0;
            rt.dir_z   <= 32'd0;
            rt.pix_valid <= 1'b0;
            rt.pix_row <= 11'd0;
            rt.pix_col <= 11'd0;
            rt.pix_hit <= 1'b0;
            rt.pix_t   <= 32'd0;
            rt.pix_nx  <= 32'd0;
            rt.pix_ny  <= 32'd0;
            rt.pix_nz  <= 32'd0;
`ifdef RAY_DISPATCHER_TIMEOUT_EN
            wdog       <= 16'd0;
            timeout    <= 1'b0;
`endif
        end else begin
            done_q     <= rt.done;
            frame_done <= 1'b0;
            rt.valid   <= 1'b0;
`ifdef RAY_DISPATCHER_TIMEOUT_EN
            timeout    <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (start) begin
                        i        <= 11'd0;
                        j        <= 11'd0;
                        busy     <= 1'b1;
                        rt.valid <= 1'b1;
                        rt.dir_x <= dir_x_of(11'd0);
                        rt.dir_y <= dir_y_of(11'd0);
                        rt.dir_z <= DIR_Z;
                        state    <= ISSUE;
                    end
                end
                ISSUE: begin
`ifdef RAY_DISPATCHER_TIMEOUT_EN
                    wdog  <= 16'd0;
`endif
                    state <= WAIT;
                end
                WAIT: begin
                    if (done_rise) begin
                        rt.pix_valid <= 1'b1;
                        rt.pix_row   <= i;
                        rt.pix_col   <= j;
                        rt.pix_hit   <= rt.intersected;
                        rt.pix_t     <= rt.t;
                        rt.pix_nx    <= rt.n_x;
                        rt.pix_ny    <= rt.n_y;
                        rt.pix_nz    <= rt.n_z;
                        state        <= OUT;
                    end
`ifdef RAY_DISPATCHER_TIMEOUT_EN
                    else if (wdog == 16'hFFFF) begin
                        rt.pix_valid <= 1'b1;
                        rt.pix_row   <= i;
                        rt.pix_col   <= j;
                        rt.pix_hit   <= 1'b0;
                        rt.pix_t     <= 32'd0;
                        rt.pix_nx    <= 32'd0;
                        rt.pix_ny    <= 32'd0;
                        rt.pix_nz    <= 32'd0;
                        timeout      <= 1'b1;
                        state        <= OUT;
                    end else begin
                        wdog <= wdog + 16'd1;
                    end
`endif
                end
                OUT: begin
                    if (rt.pix_ready) begin
                        rt.pix_valid <= 1'b0;
                        if (last_pix) begin
                            frame_done <= 1'b1;
                            busy       <= 1'b0;
                            state      <= IDLE;
                        end else begin
                            i <= i_adv;
                            j <= j_adv;
                            if (GAP_CYCLES == 0) begin
                                rt.valid <= 1'b1;
                                rt.dir_x <= dir_x_of(j_adv);
                                rt.dir_y <= dir_y_of(i_adv);
                                rt.dir_z <= DIR_Z;
                                state    <= ISSUE;
                            end else begin
                                gap_cnt <= 8'd0;
                                state   <= GAP;
                            end
                        end
                    end
                end
                GAP: begin
                    if (gap_cnt == 8'(GAP_CYCLES - 1)) begin
                        rt.valid <= 1'b1;
                        rt.dir_x <= dir_x_of(j);
                        rt.dir_y <= dir_y_of(i);
                        rt.dir_z <= DIR_Z;
                        state    <= ISSUE;
                    end else begin
                        gap_cnt <= gap_cnt + 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ray_dispatcher.sv
// Directed bench for ray_dispatcher: a 4x3 / GAP 5 instance with a scripted or
// automatic rtunit model, plus a 3x2 / GAP 0 instance for the zero-gap and
// zero-direction cases.
module tb_ray_dispatcher;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset = 1'b1;
    logic start = 1'b0;
    logic busy, frame_done;
    logic [2:0] dbg_state;

    logic start2 = 1'b0;
    logic busy2, frame_done2;
    logic [2:0] dbg_state2;

`ifdef RAY_DISPATCHER_TIMEOUT_EN
    logic timeout, timeout2;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    // ---------------- DUT 1: 4x3, GAP 5 ----------------
    ray_dispatcher_if bus ();

    logic        auto_en = 1'b0;
    logic        ready   = 1'b0;
    logic        man_done = 1'b0;
    logic        man_hit  = 1'b0;
    logic [31:0] man_t    = 32'd0;
    logic [31:0] man_nx   = 32'd0;
    logic        m_done = 1'b0;
    logic        m_hit  = 1'b0;
    logic [31:0] m_t    = 32'd0;
    logic        m_pend = 1'b0;
    int          m_cnt  = 0;

    assign bus.done        = auto_en ? m_done : man_done;
    assign bus.intersected = auto_en ? m_hit  : man_hit;
    assign bus.t           = auto_en ? m_t    : man_t;
    assign bus.n_x         = auto_en ? ~m_t   : man_nx;
    assign bus.n_y         = 32'h3F000000;
    assign bus.n_z         = 32'hBF000000;
    assign bus.u           = 32'd0;
    assign bus.v           = 32'd0;
    assign bus.pix_ready   = ready;

    ray_dispatcher #(
        .WIDTH(4), .HEIGHT(3), .FOCAL(100), .GAP_CYCLES(5)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy),
        .frame_done(frame_done), .dbg_state(dbg_state), .rt(bus)
`ifdef RAY_DISPATCHER_TIMEOUT_EN
        , .timeout(timeout)
`endif
    );

    // ---------------- DUT 2: 3x2, GAP 0 ----------------
    ray_dispatcher_if bus2 ();
    logic done2  = 1'b0;
    logic ready2 = 1'b0;

    assign bus2.done        = done2;
    assign bus2.intersected = 1'b0;
    assign bus2.t           = 32'd0;
    assign bus2.u           = 32'd0;
    assign bus2.v           = 32'd0;
    assign bus2.n_x         = 32'd0;
    assign bus2.n_y         = 32'd0;
    assign bus2.n_z         = 32'd0;
    assign bus2.pix_ready   = ready2;

    ray_dispatcher #(
        .WIDTH(3), .HEIGHT(2), .FOCAL(100), .GAP_CYCLES(0)
    ) dut2 (
        .clk(clk), .reset(reset), .start(start2), .busy(busy2),
        .frame_done(frame_done2), .dbg_state(dbg_state2), .rt(bus2)
`ifdef RAY_DISPATCHER_TIMEOUT_EN
        , .timeout(timeout2)
`endif
    );

    // ---------------- rtunit model: done one cycle after a request, held one cycle ----------------
    always @(negedge clk) begin
        m_done = 1'b0;
        if (!auto_en) begin
            m_pend = 1'b0;
        end else begin
            if (m_pend) begin
                m_done = 1'b1;
                m_hit  = m_cnt[0];
                m_t    = 32'h40000000 + 32'(m_cnt);
                m_cnt  = m_cnt + 1;
                m_pend = 1'b0;
            end
            if (bus.valid) m_pend = 1'b1;
        end
    end

    // ---------------- scoreboard ----------------
    logic [54:0] exp_q[$];   // {row, col, hit, t}

    // ---------------- tests ----------------
    task automatic test_reset;
        reset = 1'b1;
        start = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++; if (dbg_state !== 3'd0) begin n_fail++; $display("FAIL reset_state: got %0d expected 0", dbg_state); end
        n_checks++; if (bus.valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", bus.valid); end
        n_checks++; if (bus.pix_valid !== 1'b0) begin n_fail++; $display("FAIL reset_pix_valid: got %b expected 0", bus.pix_valid); end
        n_checks++; if (busy !== 1'b0 || frame_done !== 1'b0) begin n_fail++; $display("FAIL reset_busy_fd: got %b%b expected 00", busy, frame_done); end
        n_checks++; if ({bus.dir_x, bus.dir_y, bus.dir_z} !== 96'd0) begin n_fail++; $display("FAIL reset_dir: got %h %h %h expected 0", bus.dir_x, bus.dir_y, bus.dir_z); end
        n_checks++; if ({bus.pix_row, bus.pix_col, bus.pix_hit, bus.pix_t, bus.pix_nx} !== 87'd0) begin n_fail++; $display("FAIL reset_pix: got %0d %0d %b %h %h expected 0", bus.pix_row, bus.pix_col, bus.pix_hit, bus.pix_t, bus.pix_nx); end
        n_checks++; if (bus.tmax !== 32'h7F7FFFFF || bus.origin_z !== 32'h3F800000 || bus.origin_x !== 32'd0) begin n_fail++; $display("FAIL reset_consts: got tmax %h oz %h ox %h expected 7f7fffff 3f800000 0", bus.tmax, bus.origin_z, bus.origin_x); end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_first_ray;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_checks++; if (bus.valid !== 1'b1) begin n_fail++; $display("FAIL first_valid: got %b expected 1", bus.valid); end
        n_checks++; if (bus.dir_x !== 32'hC0400000) begin n_fail++; $display("FAIL first_dir_x: got %h expected c0400000", bus.dir_x); end
        n_checks++; if (bus.dir_y !== 32'h40000000) begin n_fail++; $display("FAIL first_dir_y: got %h expected 40000000", bus.dir_y); end
        n_checks++; if (bus.dir_z !== 32'hC2C80000) begin n_fail++; $display("FAIL first_dir_z: got %h expected c2c80000", bus.dir_z); end
        n_checks++; if (bus.tmax !== 32'h7F7FFFFF) begin n_fail++; $display("FAIL first_tmax: got %h expected 7f7fffff", bus.tmax); end
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL first_busy: got %b expected 1", busy); end
        @(negedge clk);
        n_checks++; if (bus.valid !== 1'b0 || dbg_state !== 3'd2) begin n_fail++; $display("FAIL valid_one_cycle: got valid %b state %0d expected 0 2", bus.valid, dbg_state); end
    endtask

    // done held high 4 cycles yields exactly one captured record.
    task automatic test_done_hold;
        man_done = 1'b1;
        man_hit  = 1'b1;
        man_nx   = 32'h3F800000;
        man_t    = 32'h40A00000;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (c == 0) begin
                n_checks++; if (bus.pix_valid !== 1'b1) begin n_fail++; $display("FAIL hold_pix_valid: got %b expected 1", bus.pix_valid); end
                n_checks++; if (bus.pix_hit !== 1'b1 || bus.pix_nx !== 32'h3F800000) begin n_fail++; $display("FAIL hold_pix_fields: got hit %b nx %h expected 1 3f800000", bus.pix_hit, bus.pix_nx); end
                n_checks++; if (bus.pix_t !== 32'h40A00000 || bus.pix_ny !== 32'h3F000000) begin n_fail++; $display("FAIL hold_pix_t_ny: got %h %h expected 40a00000 3f000000", bus.pix_t, bus.pix_ny); end
                n_checks++; if (bus.pix_row !== 11'd0 || bus.pix_col !== 11'd0) begin n_fail++; $display("FAIL hold_pix_pos: got %0d,%0d expected 0,0", bus.pix_row, bus.pix_col); end
            end
        end
        man_done = 1'b0;
        man_hit  = 1'b0;
        man_t    = 32'd0;
        man_nx   = 32'd0;
    endtask

    // Backpressure: record frozen for 10 cycles, then accept -> next valid after 6 cycles.
    task automatic test_backpressure;
        int n;
        logic extra_rec;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            n_checks++;
            if (bus.pix_valid !== 1'b1 || bus.pix_t !== 32'h40A00000 || bus.pix_nx !== 32'h3F800000 ||
                bus.pix_hit !== 1'b1 || bus.pix_col !== 11'd0 || bus.valid !== 1'b0) begin
                n_fail++;
                $display("FAIL stall_stable cycle %0d: got pv %b t %h nx %h hit %b col %0d valid %b expected 1 40a00000 3f800000 1 0 0",
                         c, bus.pix_valid, bus.pix_t, bus.pix_nx, bus.pix_hit, bus.pix_col, bus.valid);
            end
        end
        ready = 1'b1;
        n = 0;
        extra_rec = 1'b0;
        while (n < 20) begin
            @(negedge clk);
            n++;
            if (bus.valid) break;
            if (bus.pix_valid) extra_rec = 1'b1;
        end
        ready = 1'b0;
        n_checks++; if (n !== 6) begin n_fail++; $display("FAIL accept_to_valid: got %0d cycles expected 6", n); end
        n_checks++; if (extra_rec !== 1'b0) begin n_fail++; $display("FAIL single_record: got extra record %b expected 0", extra_rec); end
        n_checks++; if (bus.dir_x !== 32'hBF800000 || bus.dir_y !== 32'h40000000) begin n_fail++; $display("FAIL pix01_dir: got %h %h expected bf800000 40000000", bus.dir_x, bus.dir_y); end
    endtask

    task automatic test_reset_in_wait;
        @(negedge clk);
        n_checks++; if (dbg_state !== 3'd2) begin n_fail++; $display("FAIL pre_reset_wait: got state %0d expected 2", dbg_state); end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        n_checks++; if (dbg_state !== 3'd0 || bus.valid !== 1'b0 || bus.pix_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL reset_in_wait: got state %0d valid %b pv %b busy %b expected 0 0 0 0", dbg_state, bus.valid, bus.pix_valid, busy); end
        man_done = 1'b1;
        man_hit  = 1'b1;
        repeat (2) @(negedge clk);
        man_done = 1'b0;
        man_hit  = 1'b0;
        @(negedge clk);
        n_checks++; if (bus.pix_valid !== 1'b0 || dbg_state !== 3'd0 || busy !== 1'b0) begin n_fail++; $display("FAIL late_done_ignored: got pv %b state %0d busy %b expected 0 0 0", bus.pix_valid, dbg_state, busy); end
    endtask

    // Full frame with the automatic rtunit; a start mid-frame must change nothing.
    task automatic test_full_frame;
        int base, recs, nv, nfd, after, cyc;
        logic [54:0] got, exp;
        base = m_cnt;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 4; c++) begin
                int k;
                logic [31:0] tv;
                k  = base + r * 4 + c;
                tv = 32'h40000000 + 32'(k);
                exp_q.push_back({11'(r), 11'(c), tv[0], tv});
            end
        end
        auto_en = 1'b1;
        ready   = 1'b1;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        recs = 0; nv = 0; nfd = 0; after = 0; cyc = 0;
        while (cyc < 400 && after < 5) begin
            @(negedge clk);
            cyc++;
            start = 1'b0;
            if (bus.valid) begin
                nv++;
                if (nv == 12) begin
                    n_checks++; if (bus.dir_x !== 32'h40400000 || bus.dir_y !== 32'hC0000000) begin n_fail++; $display("FAIL pix23_dir: got %h %h expected 40400000 c0000000", bus.dir_x, bus.dir_y); end
                end
            end
            if (bus.pix_valid && ready) begin
                got = {bus.pix_row, bus.pix_col, bus.pix_hit, bus.pix_t};
                recs++;
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++; $display("FAIL frame_record %0d: got %h expected none", recs, got);
                end else begin
                    exp = exp_q.pop_front();
                    if (got !== exp) begin n_fail++; $display("FAIL frame_record %0d: got %h expected %h", recs, got, exp); end
                end
                if (recs == 3) start = 1'b1;
            end
            if (frame_done) nfd++;
            if (nfd > 0) after++;
        end
        auto_en = 1'b0;
        ready   = 1'b0;
        n_checks++; if (recs !== 12 || exp_q.size() !== 0) begin n_fail++; $display("FAIL frame_count: got %0d records, %0d left expected 12, 0", recs, exp_q.size()); end
        n_checks++; if (nfd !== 1) begin n_fail++; $display("FAIL frame_done_pulses: got %0d expected 1", nfd); end
        n_checks++; if (busy !== 1'b0 || dbg_state !== 3'd0) begin n_fail++; $display("FAIL frame_end_idle: got busy %b state %0d expected 0 0", busy, dbg_state); end
    endtask

    // GAP 0: accept -> next valid on the following cycle; centre column gives dir_x = +0.
    task automatic test_zero_gap;
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        n_checks++; if (bus2.valid !== 1'b1 || bus2.dir_x !== 32'hC0000000 || bus2.dir_y !== 32'h3F800000) begin n_fail++; $display("FAIL g0_first: got valid %b dx %h dy %h expected 1 c0000000 3f800000", bus2.valid, bus2.dir_x, bus2.dir_y); end
        @(negedge clk);
        done2 = 1'b1;
        @(negedge clk);
        n_checks++; if (bus2.pix_valid !== 1'b1 || busy2 !== 1'b1) begin n_fail++; $display("FAIL g0_record: got pv %b busy %b expected 1 1", bus2.pix_valid, busy2); end
        done2  = 1'b0;
        ready2 = 1'b1;
        @(negedge clk);
        ready2 = 1'b0;
        n_checks++; if (bus2.valid !== 1'b1 || bus2.pix_valid !== 1'b0) begin n_fail++; $display("FAIL g0_latency: got valid %b pv %b expected 1 0", bus2.valid, bus2.pix_valid); end
        n_checks++; if (bus2.dir_x !== 32'h00000000) begin n_fail++; $display("FAIL g0_zero_dir: got %h expected 00000000", bus2.dir_x); end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        test_reset();
        test_first_ray();
        test_done_hold();
        test_backpressure();
        test_reset_in_wait();
        test_full_frame();
        test_zero_gap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish before 200000");
        $fatal(1, "time limit");
    end

endmodule
